stream_demux_n: RTL
===================

Name: stream_demux_n

Overview:
- Parametrised, registered 1:N stream demultiplexer; successor to the team's 1:2 enable-gated demux.
- Routes one input stream to one of N_CH output channels selected per transfer.
- Every port uses a valid/ready handshake; each output channel has a one-entry holding register.
- Sits between a single producer (e.g. ALU/bus result stage) and N independent consumers; supports back-pressure per channel.

Parameters:
- DATA_W, 8, payload width in bits (>=1).
- N_CH, 4, number of output channels (2..16).
- SEL_W, derived localparam = max(1, clog2(N_CH)), select width; not overridable.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- en  in  1  global enable; low blocks new acceptances.
- in_valid  in  1  input transfer request.
- in_ready  out  1  input may be accepted this cycle.
- in_sel  in  SEL_W  destination channel index.
- in_data  in  DATA_W  payload.
- out_valid  out  N_CH  per-channel data valid.
- out_ready  in  N_CH  per-channel consumer ready.
- out_data  out  N_CH*DATA_W  flattened; channel k occupies bits [k*DATA_W +: DATA_W].
- sel_err  out  1  sticky flag: out-of-range select was accepted.

Behaviour:
- Reset (rst=1 at a clock edge): out_valid=0, all out_data=0, sel_err=0. Reset wins over any simultaneous transfer; in-flight channel data is discarded.
- in_ready (combinational):
  - 0 when en=0.
  - When in_sel < N_CH: 1 iff out_valid[in_sel]=0 or out_ready[in_sel]=1.
  - When in_sel >= N_CH: always 1.
- Accept = in_valid & in_ready.
- Latency: data is accepted at edge t and appears on out_valid/out_data of channel in_sel after edge t, i.e. one cycle.
- Per channel k, in priority order:
  - load (accept with in_sel==k): data_k <= in_data, valid_k <= 1. This covers a simultaneous drain and load, which gives back-to-back throughput of 1 per cycle.
  - drain only (valid_k & out_ready[k]): valid_k <= 0 and data_k <= 0. Invalid channels always present zero data.
  - otherwise hold. While valid_k=1 and out_ready[k]=0, data_k is stable.
- Non-selected channels are unaffected by an accept. Multiple channels may drain in the same cycle.
- Out-of-range select (N_CH not a power of 2):
  - The transfer is accepted and dropped.
  - sel_err <= 1 and stays set until reset.
- en=0 mid-operation: no new acceptance. Pending channel data still drains normally.
- in_valid=0: in_ready is still computed as above; no state change from the input side.

Optional Feature:
- Macro: STREAM_DEMUX_CNT_EN.
- Defined: adds output port ch_count (N_CH*8 bits, flattened like out_data).
  - Per-channel 8-bit counter increments on each completed output transfer (valid & ready).
  - Wraps 255 -> 0.
  - Resets to 0.
- Not defined: port and counters are absent; all other behaviour is identical.

Decomposition:
- Package stream_demux_pkg:
  - function sel_width(n) returning max(1, clog2(n)).
  - localparam CNT_W = 8.
  - default DATA_W and N_CH constants.
- Sub-module stream_demux_chan: one-entry holding register (load, drain, data, valid, optional counter). Instantiated N_CH times via generate.
- Top level holds the in_ready mux, decode and sel_err.

Test Plan:
- Reset with DATA_W=8, N_CH=4: assert rst 2 cycles with in_valid=1 -> out_valid=0000, out_data=0, sel_err=0, counters 0.
- Route: en=1, out_ready=1111, send 0xA5 to sel=2 -> next cycle out_valid=0100, channel 2 data=0xA5, others 0; in_ready=1 throughout.
- Back-pressure: out_ready[1]=0, send 0x11 then 0x22 to sel=1 -> 0x11 held, in_ready=0 on the second beat. Raise out_ready[1] -> 0x22 loads the same cycle 0x11 drains; no bubble.
- Enable gating: en=0 with in_valid=1, sel=0 -> in_ready=0, no load. A pending channel-3 word still drains when out_ready[3]=1.
- Out-of-range: N_CH=3, send sel=3 data 0x7F -> accepted, no out_valid bit set, sel_err=1 and stays 1 until rst.
- With STREAM_DEMUX_CNT_EN: 257 transfers on channel 0 -> ch_count[7:0]=1 (wrap); other counters 0.

Source files
------------

// File: rtl/stream_demux_pkg.sv
// rtl/stream_demux_pkg.sv - shared constants and helpers for the stream_demux_n family
// Optional feature macro: STREAM_DEMUX_CNT_EN (per-channel transfer counters)
package stream_demux_pkg;

  // Width of each per-channel completed-transfer counter.
  localparam int CNT_W = 8;

  // Default payload width and channel count for the top level.
  localparam int DEFAULT_DATA_W = 8;
  localparam int DEFAULT_N_CH   = 4;

  // Select width: max(1, clog2(n)). A single-channel build still needs a 1-bit select.
  function automatic int sel_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/stream_demux_chan.sv
// rtl/stream_demux_chan.sv - one-entry holding register for a single demux output channel
// Optional feature macro: STREAM_DEMUX_CNT_EN (adds the count output)
module stream_demux_chan
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data
`ifdef STREAM_DEMUX_CNT_EN
  ,
  output logic [CNT_W-1:0]  count
`endif
);

  // A word leaves the channel when it is presented and the consumer takes it.
  logic drain;
  assign drain = valid & ready;

  // Load beats drain so a simultaneous drain+load keeps one word per cycle;
  // an empty channel always shows zero data.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (drain) begin
      valid <= 1'b0;
      data  <= '0;
    end
  end

`ifdef STREAM_DEMUX_CNT_EN
  // Count completed output transfers; the counter wraps naturally at 2**CNT_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (drain) begin
      count <= count + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/stream_demux_n.sv
// rtl/stream_demux_n.sv - registered 1:N valid/ready stream demultiplexer
// Optional feature macro: STREAM_DEMUX_CNT_EN (adds ch_count output)
module stream_demux_n
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int N_CH   = DEFAULT_N_CH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [sel_width(N_CH)-1:0] in_sel,
  input  logic [DATA_W-1:0]        in_data,
  output logic [N_CH-1:0]          out_valid,
  input  logic [N_CH-1:0]          out_ready,
  output logic [N_CH*DATA_W-1:0]   out_data,
  output logic                     sel_err
`ifdef STREAM_DEMUX_CNT_EN
  ,
  output logic [N_CH*CNT_W-1:0]    ch_count
`endif
);

  localparam int SEL_W = sel_width(N_CH);

  // N_CH expressed one bit wider than the select so the range test never truncates.
  localparam logic [SEL_W:0] N_CH_L = (SEL_W + 1)'(N_CH);

  logic            in_range;
  logic            sel_busy;
  logic            accept;
  logic [N_CH-1:0] load;

  assign in_range = ({1'b0, in_sel} < N_CH_L);

  // The selected channel blocks input only when it holds a word its consumer is not taking.
  // Out-of-range selects match no channel, so they are never blocked.
  always_comb begin
    sel_busy = 1'b0;
    for (int k = 0; k < N_CH; k++) begin
      if (in_sel == SEL_W'(k)) begin
        sel_busy = out_valid[k] & ~out_ready[k];
      end
    end
  end

  assign in_ready = en & ~sel_busy;
  assign accept   = in_valid & in_ready;

  // One-hot load strobe toward the addressed channel; out-of-range accepts load nothing.
  always_comb begin
    load = '0;
    for (int k = 0; k < N_CH; k++) begin
      load[k] = accept & (in_sel == SEL_W'(k));
    end
  end

  // Sticky record that an accepted transfer was dropped for lack of a channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_err <= 1'b0;
    end else if (accept & ~in_range) begin
      sel_err <= 1'b1;
    end
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_chan
    stream_demux_chan #(
      .DATA_W (DATA_W)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .load      (load[k]),
      .load_data (in_data),
      .ready     (out_ready[k]),
      .valid     (out_valid[k]),
      .data      (out_data[k*DATA_W +: DATA_W])
`ifdef STREAM_DEMUX_CNT_EN
      ,
      .count     (ch_count[k*CNT_W +: CNT_W])
`endif
    );
  end

endmodule
